controller_poller: RTL and testbench
====================================

# controller_poller

Polls an external parallel-in/serial-out gamepad shift register (4021-style, reached through the NMOS level-shifting stage) at a fixed rate. It drives the latch and serial-clock lines, samples the serial data line and debounces each button over two polls. It presents a stable button vector plus sticky "newly pressed" flags to the CPU-side register file. It is the only block that sequences the controller port; nothing else drives `ctrl_latch`/`ctrl_clk`.

## Interface
- `NUM_BUTTONS`, 12: bits shifted per poll, bit 0 first.
- `CLK_DIV`, 250: system cycles per serial-clock half-period (50 kHz at 25 MHz); must be ≥ 4.
- `POLL_PERIOD`, 416_667: system cycles between poll starts (60 Hz); must exceed `(2 + 2*NUM_BUTTONS)*CLK_DIV + 1`.
- `clk_25mhz`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `ctrl_latch`  out  1  parallel-load strobe to the shift register; high loads.
- `ctrl_clk`  out  1  serial clock; idles high, rising edge shifts the next bit out.
- `ctrl_data`  in  1  serial data, asynchronous, active-low (0 = pressed).
- `buttons`  out  NUM_BUTTONS  debounced state, 1 = pressed.
- `pressed`  out  NUM_BUTTONS  sticky rising-edge flags of `buttons`.
- `ack`  in  1  one-cycle pulse; clears `pressed`.
- `valid`  out  1  one-cycle pulse when `buttons`/`pressed` were updated.
- `busy`  out  1  high while a poll transaction is in progress.

## Operation
- `ctrl_data` passes through a 2-flop synchronizer before use.
- A free-running poll timer counts `0..POLL_PERIOD-1` and wraps. A poll starts when the timer is 0 and the FSM is in IDLE. If the timer hits 0 outside IDLE, that poll is skipped (overrun); this cannot happen with legal parameters.
- FSM states:
  - IDLE: `ctrl_latch`=0, `ctrl_clk`=1. Moves to LATCH on poll start.
  - LATCH: `ctrl_latch`=1 for `2*CLK_DIV` cycles, then SHIFT with bit index 0.
  - SHIFT_LO: `ctrl_clk`=0 for `CLK_DIV` cycles. On the last cycle, the synchronized, inverted data is stored as sample bit[index].
  - SHIFT_HI: `ctrl_clk`=1 for `CLK_DIV` cycles. Then, if index = `NUM_BUTTONS-1`, go to DONE; otherwise increment index and go to SHIFT_LO.
  - DONE: one cycle, then IDLE.
- Debounce: the block keeps the previous poll's raw sample. In DONE, each `buttons` bit takes the new sample value only if the new and previous samples agree; otherwise it holds. The raw sample then becomes the previous sample.
- Edge flags are `buttons_next & ~buttons`.
  - In DONE: `pressed <= (ack ? 0 : pressed) | edges`. New edges win over a simultaneous `ack`.
  - Outside DONE: `ack` clears `pressed`.
- `valid`=1 for exactly the cycle after DONE, with the updated `buttons`/`pressed` already visible.
- `busy`=1 in LATCH, SHIFT_LO, SHIFT_HI and DONE.
- Phase counter is ⌈log2(2*CLK_DIV)⌉ bits wide. Bit index is ⌈log2(NUM_BUTTONS)⌉ bits wide. Poll timer is ⌈log2(POLL_PERIOD)⌉ bits wide.

## Timing
- Reset values: `ctrl_latch`=0, `ctrl_clk`=1, `buttons`=0, `pressed`=0, `valid`=0, `busy`=0. Previous sample = all released, FSM = IDLE, timer = 0.
- Reset mid-transaction aborts immediately to the reset values; no partial update of `buttons`.
- The first poll starts on the first cycle after `reset` deasserts: `busy` and `ctrl_latch` rise on the next edge.
- Transaction length is `(2 + 2*NUM_BUTTONS)*CLK_DIV + 1` cycles from LATCH entry to IDLE (6501 with defaults).
- A press reaches `buttons` after two consecutive polls (worst case ≈ 2 poll periods).
- Sample point: `CLK_DIV` cycles after the preceding rising `ctrl_clk`, or after latch release for bit 0. Data is therefore settled for at least `CLK_DIV-2` cycles after the synchronizer.

## Structure
- Package `controller_pkg`: FSM state enum (IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE) and default-parameter localparams shared with the register file.
- Sub-module `bit_sync`: generic 2-flop synchronizer, reset value 1 (released).
- FSM, timers and debounce logic live in `controller_poller`.

## Test plan
Bench parameters: `NUM_BUTTONS`=4, `CLK_DIV`=2, `POLL_PERIOD`=64; transaction = 21 cycles.
1. Release `reset` with `ctrl_data` held 1:
   - `ctrl_latch` high for exactly 4 cycles, then 4 clock pulses (2 low / 2 high).
   - `valid` pulses 21 cycles after LATCH entry; `buttons`=0.
   - Next LATCH starts at timer wrap (64 cycles).
2. Model presenting 4'b1010 pressed, i.e. `ctrl_data` low for bits 1 and 3:
   - First poll: `buttons`=0.
   - Second poll: `buttons`=4'b1010, `pressed`=4'b1010.
3. Bit 1 pressed on alternating polls: `buttons[1]` never changes, `pressed`=0.
4. `ack` asserted in the same cycle as DONE while bit 2 newly becomes stable-pressed and `pressed` was 4'b0001: `pressed`=4'b0100 afterwards.
5. `reset` pulsed at cycle 10 of a transaction:
   - Next cycle: `ctrl_clk`=1, `ctrl_latch`=0, `busy`=0.
   - `buttons` cleared and no `valid` pulse; a fresh poll starts after release.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types and default sizing for the gamepad controller port and its CPU-side register file.
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } poll_state_e;

  localparam int DEF_NUM_BUTTONS = 12;
  localparam int DEF_CLK_DIV     = 250;
  localparam int DEF_POLL_PERIOD = 416_667;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controller_poller_if.sv
// CPU-side view of the controller poller: debounced buttons, sticky press flags and handshake.
interface controller_poller_if
  import controller_pkg::*;
#(
  parameter int NUM_BUTTONS = DEF_NUM_BUTTONS
);

  logic [NUM_BUTTONS-1:0] buttons;
  logic [NUM_BUTTONS-1:0] pressed;
  logic                   ack;
  logic                   valid;
  logic                   busy;

  modport master (output buttons, pressed, valid, busy, input ack);
  modport slave  (input buttons, pressed, valid, busy, output ack);

endinterface

// File: rtl/bit_sync.sv
// Generic two-flop synchronizer for a single asynchronous level input.
module bit_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make q take the old meta, giving two real flop stages.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controller_poller.sv
// Periodically latches and shifts in a 4021-style gamepad register, debounces each
// button over two polls and raises sticky newly-pressed flags for the CPU.
module controller_poller
  import controller_pkg::*;
#(
  parameter int NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  output logic                ctrl_latch,
  output logic                ctrl_clk,
  input  logic                ctrl_data,
  controller_poller_if.master bus
);

  localparam int PHASE_W = width_of(2 * CLK_DIV);
  localparam int INDEX_W = width_of(NUM_BUTTONS);
  localparam int TIMER_W = width_of(POLL_PERIOD);

  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(CLK_DIV - 1);
  localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(NUM_BUTTONS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);

  poll_state_e            state;
  logic [PHASE_W-1:0]     phase;
  logic [INDEX_W-1:0]     index;
  logic [TIMER_W-1:0]     timer;
  logic                   data_sync;
  logic                   poll_start;
  logic                   busy_q;
  logic                   valid_q;
  // Samples are stored inverted so 1 = pressed throughout the datapath.
  logic [NUM_BUTTONS-1:0] sample;
  logic [NUM_BUTTONS-1:0] prev_sample;
  logic [NUM_BUTTONS-1:0] buttons_q;
  logic [NUM_BUTTONS-1:0] pressed_q;
  logic [NUM_BUTTONS-1:0] agree;
  logic [NUM_BUTTONS-1:0] buttons_next;
  logic [NUM_BUTTONS-1:0] edges;

  bit_sync #(.RESET_VALUE(1'b1)) u_data_sync (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .d         (ctrl_data),
    .q         (data_sync)
  );

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign poll_start = (timer == '0);

  // A button only moves when two consecutive polls agree on its level.
  assign agree        = ~(sample ^ prev_sample);
  assign buttons_next = (agree & sample) | (~agree & buttons_q);
  assign edges        = buttons_next & ~buttons_q;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      index       <= '0;
      ctrl_latch  <= 1'b0;
      ctrl_clk    <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sample      <= '0;
      prev_sample <= '0;
      buttons_q   <= '0;
      pressed_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      // NOTE: the DONE branch below assigns pressed_q again; the later non-blocking write wins.
      if (bus.ack) pressed_q <= '0;

      case (state)
        IDLE: begin
          if (poll_start) begin
            state      <= LATCH;
            phase      <= '0;
            ctrl_latch <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        LATCH: begin
          if (phase == LATCH_LAST) begin
            state      <= SHIFT_LO;
            phase      <= '0;
            index      <= '0;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        SHIFT_LO: begin
          if (phase == HALF_LAST) begin
            sample[index] <= ~data_sync;
            state         <= SHIFT_HI;
            phase         <= '0;
            ctrl_clk      <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            if (index == INDEX_LAST) begin
              state <= DONE;
            end else begin
              index    <= index + 1'b1;
              state    <= SHIFT_LO;
              ctrl_clk <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        DONE: begin
          buttons_q   <= buttons_next;
          pressed_q   <= (bus.ack ? '0 : pressed_q) | edges;
          prev_sample <= sample;
          valid_q     <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.buttons = buttons_q;
  assign bus.pressed = pressed_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_controller_poller.sv
// Drives controller_poller against a behavioural 4021 gamepad and checks each poll
// against a poll-level debounce/edge-flag reference model.
module tb_controller_poller;

  localparam int NB  = 4;
  localparam int CD  = 2;
  localparam int PP  = 64;
  localparam int TXN = (2 + 2 * NB) * CD + 1;

  logic clk_25mhz = 1'b0;
  logic reset;
  logic ctrl_latch;
  logic ctrl_clk;
  logic ctrl_data;

  controller_poller_if #(.NUM_BUTTONS(NB)) bus ();

  controller_poller #(
    .NUM_BUTTONS (NB),
    .CLK_DIV     (CD),
    .POLL_PERIOD (PP)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .ctrl_latch (ctrl_latch),
    .ctrl_clk   (ctrl_clk),
    .ctrl_data  (ctrl_data),
    .bus        (bus)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Gamepad: parallel load while latch is high, shift toward bit 0 on rising serial clock.
  logic [NB-1:0] pad;
  logic [NB-1:0] sr;
  logic          clk_prev;

  initial begin
    pad       = '0;
    sr        = '0;
    clk_prev  = 1'b1;
    ctrl_data = 1'b1;
    forever begin
      @(negedge clk_25mhz);
      if (ctrl_latch === 1'b1) sr = pad;
      else if (ctrl_clk === 1'b1 && clk_prev === 1'b0) sr = sr >> 1;
      clk_prev  = ctrl_clk;
      ctrl_data = ~sr[0];
    end
  end

  // Reference: state after each completed poll, from the debounce and flag rules.
  logic [NB-1:0] m_buttons = '0;
  logic [NB-1:0] m_pressed = '0;
  logic [NB-1:0] m_prev    = '0;

  task automatic model_poll(input logic [NB-1:0] s, input bit ack_done);
    logic [NB-1:0] nxt;
    for (int i = 0; i < NB; i++) nxt[i] = (s[i] == m_prev[i]) ? s[i] : m_buttons[i];
    m_pressed = (ack_done ? '0 : m_pressed) | (nxt & ~m_buttons);
    m_buttons = nxt;
    m_prev    = s;
  endtask

  int latch_cyc;

  task automatic wait_latch(output int waited);
    waited = 0;
    do begin
      @(negedge clk_25mhz);
      waited++;
    end while (ctrl_latch !== 1'b1 && waited < 3 * PP);
    check("poll_start", ctrl_latch, 1);
    latch_cyc = cyc;
  endtask

  // Called on the LATCH-entry cycle; steps to DONE, optionally acks there, then checks.
  task automatic finish_poll(input logic [NB-1:0] v, input bit ack_done, input string tag);
    repeat (TXN - 1) @(negedge clk_25mhz);
    if (ack_done) bus.ack = 1'b1;
    @(negedge clk_25mhz);
    bus.ack = 1'b0;
    model_poll(v, ack_done);
    check({tag, "_valid"},   bus.valid,   1);
    check({tag, "_buttons"}, bus.buttons, m_buttons);
    check({tag, "_pressed"}, bus.pressed, m_pressed);
  endtask

  task automatic do_poll(input logic [NB-1:0] v, input bit ack_done, input string tag);
    int w;
    pad = v;
    wait_latch(w);
    finish_poll(v, ack_done, tag);
  endtask

  task automatic idle_ack();
    bus.ack = 1'b1;
    @(negedge clk_25mhz);
    bus.ack = 1'b0;
    m_pressed = '0;
    check("idle_ack_pressed", bus.pressed, m_pressed);
  endtask

  logic [TXN:0]  lt, ck, by, vd;
  logic [TXN:0]  e_lt, e_ck, e_by, e_vd;
  logic [NB-1:0] rv;
  int            w;
  int            c0;
  int            mode;

  initial begin
    reset   = 1'b1;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    check("rst_latch",   ctrl_latch,  0);
    check("rst_clk",     ctrl_clk,    1);
    check("rst_buttons", bus.buttons, 0);
    check("rst_pressed", bus.pressed, 0);
    check("rst_valid",   bus.valid,   0);
    check("rst_busy",    bus.busy,    0);

    // Idle pad: timing of one full transaction.
    reset = 1'b0;
    wait_latch(w);
    check("first_poll_delay", w, 1);
    c0 = latch_cyc;
    for (int k = 0; k <= TXN; k++) begin
      if (k > 0) @(negedge clk_25mhz);
      lt[k] = ctrl_latch;
      ck[k] = ctrl_clk;
      by[k] = bus.busy;
      vd[k] = bus.valid;
    end
    for (int k = 0; k <= TXN; k++) begin
      e_lt[k] = (k < 2 * CD);
      e_by[k] = (k < TXN);
      e_vd[k] = (k == TXN);
      e_ck[k] = 1'b1;
      if (k >= 2 * CD && k < TXN - 1) e_ck[k] = (((k - 2 * CD) / CD) % 2) == 1;
    end
    check("trace_latch", 32'(lt), 32'(e_lt));
    check("trace_clk",   32'(ck), 32'(e_ck));
    check("trace_busy",  32'(by), 32'(e_by));
    check("trace_valid", 32'(vd), 32'(e_vd));
    model_poll('0, 1'b0);
    check("poll1_buttons", bus.buttons, m_buttons);
    do_poll('0, 1'b0, "poll2");
    check("poll_period", latch_cyc - c0, PP);

    // Two agreeing polls needed before a press shows.
    do_poll(4'b1010, 1'b0, "t2a");
    check("t2a_not_yet", bus.buttons, 0);
    do_poll(4'b1010, 1'b0, "t2b");
    check("t2b_pressed", bus.pressed, 4'b1010);
    idle_ack();

    // Bit 1 bouncing every poll never settles to a new value.
    for (int i = 0; i < 4; i++) begin
      do_poll((i % 2 == 0) ? 4'b1000 : 4'b1010, 1'b0, "t3");
      check("t3_btn1", bus.buttons[1], 1);
    end

    // New edge wins over an ack in the same DONE cycle.
    do_poll(4'b0000, 1'b0, "t4a");
    do_poll(4'b0000, 1'b0, "t4b");
    idle_ack();
    do_poll(4'b0001, 1'b0, "t4c");
    do_poll(4'b0001, 1'b0, "t4d");
    do_poll(4'b0101, 1'b0, "t4e");
    check("t4_pressed_before", bus.pressed, 4'b0001);
    do_poll(4'b0101, 1'b1, "t4f");
    check("t4_pressed_after", bus.pressed, 4'b0100);

    // Reset in the middle of a transaction.
    pad = 4'b0101;
    wait_latch(w);
    repeat (10) @(negedge clk_25mhz);
    reset = 1'b1;
    @(negedge clk_25mhz);
    check("t5_clk",     ctrl_clk,    1);
    check("t5_latch",   ctrl_latch,  0);
    check("t5_busy",    bus.busy,    0);
    check("t5_buttons", bus.buttons, 0);
    check("t5_pressed", bus.pressed, 0);
    check("t5_valid0",  bus.valid,   0);
    repeat (2) begin
      @(negedge clk_25mhz);
      check("t5_valid_hold", bus.valid, 0);
    end
    reset = 1'b0;
    m_buttons = '0;
    m_pressed = '0;
    m_prev    = '0;
    wait_latch(w);
    check("t5_restart_delay", w, 1);
    finish_poll(4'b0101, 1'b0, "t5a");
    do_poll(4'b0101, 1'b0, "t5b");

    // Random pads with random acknowledge placement.
    rv = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) rv = NB'($urandom_range(0, 15));
      if (mode == 1) idle_ack();
      do_poll(rv, mode == 2, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
